control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle control unit for the 16-bit datapath. It sequences fetch, decode, execute, memory and writeback, and drives the select and enable lines for the PC, instruction register, register file, memory port and ALU. Its `alu_signal` output is the ALU's `operation` input: 1 selects add with carry-in 0, 0 selects bitwise AND. It is the decision-making end of the ALU control interface and sits between the instruction register and the datapath muxes.

## Interface
- `OPW`, 4: opcode width; opcode is `instr[15:12]`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr`  in  16  instruction register contents; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `mem_read`  out  1  memory read request; held until `mem_ready`.
- `mem_write`  out  1  memory write request; held until `mem_ready`.
- `iord`  out  1  address select: 0 = PC, 1 = ALU result register.
- `ir_write`  out  1  load instruction register.
- `pc_inc`  out  1  PC <= PC + 1.
- `pc_load`  out  1  PC <= `instr[11:0]`, zero-extended.
- `alu_signal`  out  1  ALU operation: 1 = add, 0 = AND.
- `alu_src_imm`  out  1  ALU B operand: 0 = register, 1 = sign-extended `instr[5:0]`.
- `reg_write`  out  1  register file write enable.
- `wb_sel`  out  1  writeback source: 0 = ALU, 1 = memory data.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Opcodes:
  - 0000 AND, 0001 ADD (register-register).
  - 0010 ANDI, 0011 ADDI (register-immediate).
  - 0100 LD, 0101 ST.
  - 0110 JUMP.
  - 0111 HALT.
  - 1000–1111 undefined.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - `mem_read`=1, `iord`=0.
  - On `mem_ready`: `ir_write`=1 and `pc_inc`=1 for that cycle only (Mealy outputs); go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: no outputs asserted; register file reads settle; go to EXEC.
- EXEC:
  - AND/ANDI: `alu_signal`=0. ADD/ADDI/LD/ST: `alu_signal`=1.
  - `alu_src_imm`=1 for ANDI/ADDI/LD/ST.
  - Register-register and immediate ops go to WB. LD/ST go to MEM.
  - JUMP: `pc_load`=1, go to FETCH.
  - HALT: go to HALT.
  - Undefined: `illegal`=1, go to FETCH (executes as a no-op).
- MEM:
  - `iord`=1. LD: `mem_read`=1. ST: `mem_write`=1.
  - Requests are held until `mem_ready`. Then LD goes to WB and ST goes to FETCH.
- WB: `reg_write`=1. `wb_sel`=1 for LD, 0 otherwise. Go to FETCH.
- HALT: `halted`=1; stays in HALT until `rst`.
- Outputs not listed for a state are 0. `mem_read` and `mem_write` are never high together.
- `alu_signal` is 0 outside EXEC and MEM. During MEM it holds the EXEC value, so the address stays stable.

## Timing
- Reset:
  - `rst` forces the state to FETCH immediately, without waiting for a clock edge.
  - While `rst`=1, all outputs are 0.
  - `mem_read` rises combinationally once `rst` deasserts.
- Reset mid-operation abandons any pending memory request. No `reg_write` or `pc_*` pulse follows.
- Latency with `mem_ready` high at every request, counted from the FETCH cycle to the next FETCH:
  - AND/ADD/ANDI/ADDI: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - JUMP: 3 cycles.
  - Undefined opcode: 3 cycles.
- Each cycle of `mem_ready`=0 during FETCH or MEM adds exactly one cycle.
- `mem_ready` outside FETCH and MEM is ignored.
- All state transitions happen on the rising edge of `clk`.

## Structure
- Shared package `cpu_pkg`:
  - Opcode localparams: `OP_AND` through `OP_HALT`.
  - State encoding (3 bits): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
  - `ALU_ADD`=1, `ALU_AND`=0.
  - The datapath and the ALU's callers use the same package.
- Sub-module `ctrl_decode`: combinational; maps the opcode to class flags `is_rr`, `is_imm`, `is_ld`, `is_st`, `is_jmp`, `is_halt`, `is_add`, `is_illegal`.
- `control_unit` holds only the state register and the per-state output logic.

## Test plan
- ADD (`instr`=16'h1xxx), `mem_ready` tied 1 → FETCH, DECODE, EXEC (`alu_signal`=1, `alu_src_imm`=0), WB (`reg_write`=1, `wb_sel`=0), back to FETCH on cycle 5.
- LD (16'h4xxx) with `mem_ready` low for 2 cycles in MEM → `mem_read`=1 and `iord`=1 held for 3 cycles, then WB with `wb_sel`=1. Total 7 cycles.
- ST (16'h5xxx), then JUMP (16'h6123) → one `mem_write` cycle; `pc_load`=1 in the JUMP EXEC cycle; no `reg_write` for either.
- Opcode 16'hF000 → `illegal` pulses 1 cycle in EXEC, return to FETCH; no `reg_write`, no `pc_load`.
- HALT (16'h7000) → `halted`=1 and the FSM stays there for 20 cycles with no requests. Asserting `rst` returns it to FETCH.
- `rst` asserted mid-MEM of an LD, off the clock edge → all outputs 0 immediately; after release, FETCH with `mem_read`=1 and no stray `reg_write`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: opcodes, FSM state encoding,
// ALU operation codes and the decoded instruction-class flags.
package cpu_pkg;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ANDI = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_JUMP = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;

  localparam logic ALU_ADD = 1'b1;
  localparam logic ALU_AND = 1'b0;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Instruction class flags produced by ctrl_decode.
  typedef struct packed {
    logic is_rr;
    logic is_imm;
    logic is_ld;
    logic is_st;
    logic is_jmp;
    logic is_halt;
    logic is_add;
    logic is_illegal;
  } dec_t;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath/memory signal bundle. The master side is the
// control unit; the slave side is the datapath that obeys it.
interface control_unit_if;
  logic [15:0] instr;
  logic        mem_ready;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic        ir_write;
  logic        pc_inc;
  logic        pc_load;
  logic        alu_signal;
  logic        alu_src_imm;
  logic        reg_write;
  logic        wb_sel;
  logic        halted;
  logic        illegal;

  modport master (
    input  instr, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_inc, pc_load,
           alu_signal, alu_src_imm, reg_write, wb_sel, halted, illegal
  );

  modport slave (
    output instr, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_inc, pc_load,
           alu_signal, alu_src_imm, reg_write, wb_sel, halted, illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier. Anything outside the defined opcode
// set is flagged illegal and belongs to no other class.
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode_i,
  output dec_t           dec_o
);

  // Map opcode to exactly one class (plus the add/and ALU selector).
  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OPW'(OP_AND):  dec_o.is_rr  = 1'b1;
      OPW'(OP_ADD):  begin dec_o.is_rr  = 1'b1; dec_o.is_add = 1'b1; end
      OPW'(OP_ANDI): dec_o.is_imm = 1'b1;
      OPW'(OP_ADDI): begin dec_o.is_imm = 1'b1; dec_o.is_add = 1'b1; end
      OPW'(OP_LD):   begin dec_o.is_ld  = 1'b1; dec_o.is_add = 1'b1; end
      OPW'(OP_ST):   begin dec_o.is_st  = 1'b1; dec_o.is_add = 1'b1; end
      OPW'(OP_JUMP): dec_o.is_jmp     = 1'b1;
      OPW'(OP_HALT): dec_o.is_halt    = 1'b1;
      default:       dec_o.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Outputs are decoded from the state (plus mem_ready in FETCH/MEM) and are
// forced low while rst is high, so an async reset silences the datapath
// immediately and drops any pending memory request.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic            clk,
  input  logic            rst,
  control_unit_if.master  bus
);

  state_t state_q, state_d;
  dec_t   dec;

  logic mem_read, mem_write, iord, ir_write, pc_inc, pc_load;
  logic alu_signal, alu_src_imm, reg_write, wb_sel, halted, illegal;

  ctrl_decode #(.OPW(OPW)) u_dec (
    .opcode_i (bus.instr[15 -: OPW]),
    .dec_o    (dec)
  );

  // State register; reset lands in FETCH without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_d     = state_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    alu_signal  = ALU_AND;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (bus.mem_ready) begin
            ir_write = 1'b1;
            pc_inc   = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          alu_signal  = dec.is_add ? ALU_ADD : ALU_AND;
          alu_src_imm = dec.is_imm | dec.is_ld | dec.is_st;
          if (dec.is_rr || dec.is_imm)      state_d = S_WB;
          else if (dec.is_ld || dec.is_st)  state_d = S_MEM;
          else if (dec.is_jmp) begin
            pc_load = 1'b1;
            state_d = S_FETCH;
          end
          else if (dec.is_halt)             state_d = S_HALT;
          else begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_MEM: begin
          // Keep the address-generating ALU op stable while memory works.
          alu_signal  = dec.is_add ? ALU_ADD : ALU_AND;
          alu_src_imm = 1'b1;
          iord        = 1'b1;
          mem_read    = dec.is_ld;
          mem_write   = dec.is_st;
          if (bus.mem_ready) state_d = dec.is_ld ? S_WB : S_FETCH;
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = dec.is_ld;
          state_d   = S_FETCH;
        end
        S_HALT:  halted  = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.iord        = iord;
  assign bus.ir_write    = ir_write;
  assign bus.pc_inc      = pc_inc;
  assign bus.pc_load     = pc_load;
  assign bus.alu_signal  = alu_signal;
  assign bus.alu_src_imm = alu_src_imm;
  assign bus.reg_write   = reg_write;
  assign bus.wb_sel      = wb_sel;
  assign bus.halted      = halted;
  assign bus.illegal     = illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit. Outputs are packed into one 12-bit word
// {mem_read, mem_write, iord, ir_write, pc_inc, pc_load, alu_signal,
//  alu_src_imm, reg_write, wb_sel, halted, illegal} and compared per cycle
// against hand-computed constants.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  control_unit_if bus();

  control_unit #(.OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] outs;
  assign outs = {bus.mem_read, bus.mem_write, bus.iord, bus.ir_write,
                 bus.pc_inc, bus.pc_load, bus.alu_signal, bus.alu_src_imm,
                 bus.reg_write, bus.wb_sel, bus.halted, bus.illegal};

  localparam logic [11:0] O_NONE   = 12'h000;
  localparam logic [11:0] O_FWAIT  = 12'h800; // mem_read
  localparam logic [11:0] O_FRDY   = 12'h980; // mem_read, ir_write, pc_inc
  localparam logic [11:0] O_EADD   = 12'h020; // alu add, reg operand
  localparam logic [11:0] O_EADDI  = 12'h030; // alu add, imm operand (also LD/ST)
  localparam logic [11:0] O_EANDI  = 12'h010; // alu and, imm operand
  localparam logic [11:0] O_MLD    = 12'hA30; // mem_read, iord, alu add, imm
  localparam logic [11:0] O_MST    = 12'h630; // mem_write, iord, alu add, imm
  localparam logic [11:0] O_WBALU  = 12'h008;
  localparam logic [11:0] O_WBMEM  = 12'h00C;
  localparam logic [11:0] O_EJMP   = 12'h040;
  localparam logic [11:0] O_EILL   = 12'h001;
  localparam logic [11:0] O_HALT   = 12'h002;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask

  // Apply inputs just after a rising edge, check outputs, then advance.
  task automatic cyc(input string tag, input logic rdy, input logic [15:0] ins,
                     input logic [11:0] exp);
    bus.mem_ready = rdy;
    bus.instr     = ins;
    #1;
    chk(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.instr     = 16'h0000;
    #12;
    chk("reset_quiet", outs, O_NONE);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_reset_fetch", outs, O_FWAIT);
    @(posedge clk); #1;

    // ADD: FETCH, DECODE, EXEC, WB, back to FETCH on cycle 5
    cyc("add_f",  1'b1, 16'h1234, O_FRDY);
    cyc("add_d",  1'b1, 16'h1234, O_NONE);
    cyc("add_e",  1'b1, 16'h1234, O_EADD);
    cyc("add_wb", 1'b1, 16'h1234, O_WBALU);

    // ANDI and AND: ALU select low
    cyc("andi_f",  1'b1, 16'h2abc, O_FRDY);
    cyc("andi_d",  1'b0, 16'h2abc, O_NONE);
    cyc("andi_e",  1'b0, 16'h2abc, O_EANDI);
    cyc("andi_wb", 1'b0, 16'h2abc, O_WBALU);
    cyc("addi_f",  1'b1, 16'h3001, O_FRDY);
    cyc("addi_d",  1'b1, 16'h3001, O_NONE);
    cyc("addi_e",  1'b1, 16'h3001, O_EADDI);
    cyc("addi_wb", 1'b1, 16'h3001, O_WBALU);
    // one FETCH wait cycle before AND
    cyc("and_fw",  1'b0, 16'h0fff, O_FWAIT);
    cyc("and_f",   1'b1, 16'h0fff, O_FRDY);
    cyc("and_d",   1'b1, 16'h0fff, O_NONE);
    cyc("and_e",   1'b1, 16'h0fff, O_NONE);
    cyc("and_wb",  1'b1, 16'h0fff, O_WBALU);

    // LD with two MEM wait cycles: 7 cycles total
    cyc("ld_f",   1'b1, 16'h4321, O_FRDY);
    cyc("ld_d",   1'b1, 16'h4321, O_NONE);
    cyc("ld_e",   1'b1, 16'h4321, O_EADDI);
    cyc("ld_m0",  1'b0, 16'h4321, O_MLD);
    cyc("ld_m1",  1'b0, 16'h4321, O_MLD);
    cyc("ld_m2",  1'b1, 16'h4321, O_MLD);
    cyc("ld_wb",  1'b1, 16'h4321, O_WBMEM);

    // ST then JUMP
    cyc("st_f",   1'b1, 16'h5010, O_FRDY);
    cyc("st_d",   1'b1, 16'h5010, O_NONE);
    cyc("st_e",   1'b1, 16'h5010, O_EADDI);
    cyc("st_m",   1'b1, 16'h5010, O_MST);
    cyc("jmp_f",  1'b1, 16'h6123, O_FRDY);
    cyc("jmp_d",  1'b1, 16'h6123, O_NONE);
    cyc("jmp_e",  1'b1, 16'h6123, O_EJMP);

    // Undefined opcodes
    cyc("ill_f",  1'b1, 16'hF000, O_FRDY);
    cyc("ill_d",  1'b1, 16'hF000, O_NONE);
    cyc("ill_e",  1'b1, 16'hF000, O_EILL);
    cyc("ill8_f", 1'b1, 16'h8000, O_FRDY);
    cyc("ill8_d", 1'b1, 16'h8000, O_NONE);
    cyc("ill8_e", 1'b1, 16'h8000, O_EILL);

    // HALT: stays 20 cycles regardless of mem_ready
    cyc("halt_f", 1'b1, 16'h7000, O_FRDY);
    cyc("halt_d", 1'b1, 16'h7000, O_NONE);
    cyc("halt_e", 1'b1, 16'h7000, O_NONE);
    for (int i = 0; i < 20; i++)
      cyc("halt_hold", 1'(i % 2), 16'h1000, O_HALT);
    rst = 1'b1;
    #1;
    chk("halt_rst_quiet", outs, O_NONE);
    @(posedge clk); #2;
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    chk("halt_rst_fetch", outs, O_FWAIT);
    @(posedge clk); #1;

    // Reset in the middle of an LD MEM wait, off the clock edge
    cyc("rld_f",  1'b1, 16'h4777, O_FRDY);
    cyc("rld_d",  1'b1, 16'h4777, O_NONE);
    cyc("rld_e",  1'b1, 16'h4777, O_EADDI);
    bus.mem_ready = 1'b0;
    #1;
    chk("rld_m", outs, O_MLD);
    #2;
    rst = 1'b1;
    #1;
    chk("rld_rst_quiet", outs, O_NONE);
    bus.mem_ready = 1'b1;
    @(posedge clk); #3;
    chk("rld_rst_hold", outs, O_NONE);
    bus.mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rld_fetch", outs, O_FWAIT);
    @(posedge clk); #1;
    cyc("rld_fetch2", 1'b0, 16'h4777, O_FWAIT);
    cyc("rld_fetch3", 1'b1, 16'h4777, O_FRDY);
    cyc("rld_d2",     1'b1, 16'h4777, O_NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
